// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_2r1w
//  Purpose  : Parametrised register file with one write port and two
//             independent registered read ports. Reads bypass a same-cycle
//             write, register 0 may be hardwired to zero, and any access to
//             an unimplemented address raises a sticky error flag.
//  Ports    : clk                      rising-edge clock
//             reset                    synchronous, active-high reset
//             wr_en/wr_addr/wr_data    write port
//             rd_en_x/rd_addr_x        read request, x = a|b
//             rd_data_x/rd_vld_x       registered read data and 1-cycle strobe
//             addr_err                 sticky out-of-range access flag
//  Revision : 1.0  initial release
// ============================================================================
module reg_file_2r1w #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 5,
    parameter int                DEPTH     = 32,
    parameter bit                ZERO_R0   = 1'b1,
    parameter logic [DATA_W-1:0] OOR_VALUE = DATA_W'(32)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_vld_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_vld_b,
    output logic              addr_err
);

    // The storage view spans the full address space so every read index is
    // in bounds; slots at or above DEPTH are tied to zero and never selected.
    localparam int                c_slots = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] w_mem [c_slots];

    logic              w_wr_oor;
    logic              w_wr_ok;
    logic              w_oor_a;
    logic              w_oor_b;
    logic              w_zero_a;
    logic              w_zero_b;
    logic              w_hit_a;
    logic              w_hit_b;
    logic [DATA_W-1:0] w_next_a;
    logic [DATA_W-1:0] w_next_b;

    logic [DATA_W-1:0] r_data_a;
    logic [DATA_W-1:0] r_data_b;
    logic              r_vld_a;
    logic              r_vld_b;
    logic              r_err;

    // ------------------------------------------------------------------
    // Write qualification: out-of-range writes and writes to a hardwired
    // R0 are dropped here so no storage flop sees them.
    // ------------------------------------------------------------------
    assign w_wr_oor = ({1'b0, wr_addr} >= c_depth);
    assign w_wr_ok  = wr_en && !w_wr_oor && !(ZERO_R0 && (wr_addr == '0));

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < c_slots; gi++) begin : g_reg
        if (gi >= DEPTH) begin : g_unused
            assign w_mem[gi] = '0;
        end else if (ZERO_R0 && (gi == 0)) begin : g_zero
            assign w_mem[gi] = '0;
        end else begin : g_flop
            localparam logic [ADDR_W-1:0] c_idx = ADDR_W'(gi);
            logic [DATA_W-1:0] r_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_q <= '0;
                end else if (w_wr_ok && (wr_addr == c_idx)) begin
                    r_q <= wr_data;
                end
            end

            assign w_mem[gi] = r_q;
        end
    end

    // ------------------------------------------------------------------
    // Read selection. Assignments run lowest priority first so the later
    // ones win: mem < bypass < hardwired zero < out-of-range value.
    // ------------------------------------------------------------------
    assign w_oor_a  = ({1'b0, rd_addr_a} >= c_depth);
    assign w_oor_b  = ({1'b0, rd_addr_b} >= c_depth);
    assign w_zero_a = ZERO_R0 && (rd_addr_a == '0);
    assign w_zero_b = ZERO_R0 && (rd_addr_b == '0);
    assign w_hit_a  = wr_en && (wr_addr == rd_addr_a);
    assign w_hit_b  = wr_en && (wr_addr == rd_addr_b);

    always_comb begin
        w_next_a = w_mem[rd_addr_a];
        if (w_hit_a)  w_next_a = wr_data;
        if (w_zero_a) w_next_a = '0;
        if (w_oor_a)  w_next_a = OOR_VALUE;
    end

    always_comb begin
        w_next_b = w_mem[rd_addr_b];
        if (w_hit_b)  w_next_b = wr_data;
        if (w_zero_b) w_next_b = '0;
        if (w_oor_b)  w_next_b = OOR_VALUE;
    end

    // ------------------------------------------------------------------
    // Output registers. Data holds its last value when no read is issued;
    // reset clears any read launched in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_a <= '0;
            r_data_b <= '0;
            r_vld_a  <= 1'b0;
            r_vld_b  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_vld_a <= rd_en_a;
            r_vld_b <= rd_en_b;
            if (rd_en_a) r_data_a <= w_next_a;
            if (rd_en_b) r_data_b <= w_next_b;
            if ((wr_en && w_wr_oor) || (rd_en_a && w_oor_a) || (rd_en_b && w_oor_b)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rd_data_a = r_data_a;
    assign rd_data_b = r_data_b;
    assign rd_vld_a  = r_vld_a;
    assign rd_vld_b  = r_vld_b;
    assign addr_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_2r1w
//  Purpose  : Self-checking bench for reg_file_2r1w. u0 is a 24-entry file
//             with hardwired R0; u1 is a 32-entry file without it. Stimulus
//             pushes expected read results into per-port queues; a monitor
//             pops and compares whenever a valid strobe appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_2r1w;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic        clk;
    logic        reset;

    // u0 signals
    logic        wr_en, rd_en_a, rd_en_b;
    logic [4:0]  wr_addr, rd_addr_a, rd_addr_b;
    logic [31:0] wr_data;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_vld_a, rd_vld_b, addr_err;

    // u1 signals
    logic        wr_en1, rd_en_a1, rd_en_b1;
    logic [4:0]  wr_addr1, rd_addr_a1, rd_addr_b1;
    logic [31:0] wr_data1;
    logic [31:0] rd_data_a1, rd_data_b1;
    logic        rd_vld_a1, rd_vld_b1, addr_err1;

    exp_t qa[$];
    exp_t qb[$];
    exp_t q1a[$];
    exp_t q1b[$];

    int cyc_cnt = 0;
    int n_cmp   = 0;
    int n_bad   = 0;

    reg_file_2r1w #(
        .DATA_W(32), .ADDR_W(5), .DEPTH(24), .ZERO_R0(1'b1), .OOR_VALUE(32'd32)
    ) u0 (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_vld_a(rd_vld_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_vld_b(rd_vld_b),
        .addr_err(addr_err)
    );

    reg_file_2r1w #(
        .DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_R0(1'b0), .OOR_VALUE(32'd32)
    ) u1 (
        .clk(clk), .reset(reset),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .rd_en_a(rd_en_a1), .rd_addr_a(rd_addr_a1), .rd_data_a(rd_data_a1), .rd_vld_a(rd_vld_a1),
        .rd_en_b(rd_en_b1), .rd_addr_b(rd_addr_b1), .rd_data_b(rd_data_b1), .rd_vld_b(rd_vld_b1),
        .addr_err(addr_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ------------------------------------------------------------------
    // Scoreboard monitor
    // ------------------------------------------------------------------
    task automatic judge(input string nm, input logic vld, input logic [31:0] d,
                         input int has, input exp_t f, output bit pop);
        pop = 1'b0;
        if (vld === 1'b1) begin
            n_cmp++;
            if (has == 0) begin
                n_bad++;
                $display("FAIL %s: valid with data %h at cycle %0d, required no valid", nm, d, cyc_cnt);
            end else begin
                pop = 1'b1;
                if (d !== f.d || cyc_cnt != f.due) begin
                    n_bad++;
                    $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d",
                             nm, d, cyc_cnt, f.d, f.due);
                end
            end
        end else if (has > 0 && f.due <= cyc_cnt) begin
            n_cmp++;
            n_bad++;
            pop = 1'b1;
            $display("FAIL %s: no valid at cycle %0d, required %h at cycle %0d", nm, cyc_cnt, f.d, f.due);
        end
    endtask

    always @(negedge clk) begin
        exp_t f;
        bit   p;
        if (!reset) begin
            f = (qa.size() > 0) ? qa[0] : '{d: 32'h0, due: 0};
            judge("u0_port_a", rd_vld_a, rd_data_a, qa.size(), f, p);
            if (p) void'(qa.pop_front());
            f = (qb.size() > 0) ? qb[0] : '{d: 32'h0, due: 0};
            judge("u0_port_b", rd_vld_b, rd_data_b, qb.size(), f, p);
            if (p) void'(qb.pop_front());
            f = (q1a.size() > 0) ? q1a[0] : '{d: 32'h0, due: 0};
            judge("u1_port_a", rd_vld_a1, rd_data_a1, q1a.size(), f, p);
            if (p) void'(q1a.pop_front());
            f = (q1b.size() > 0) ? q1b[0] : '{d: 32'h0, due: 0};
            judge("u1_port_b", rd_vld_b1, rd_data_b1, q1b.size(), f, p);
            if (p) void'(q1b.pop_front());
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic idle_inputs();
        wr_en  = 1'b0; rd_en_a  = 1'b0; rd_en_b  = 1'b0;
        wr_en1 = 1'b0; rd_en_a1 = 1'b0; rd_en_b1 = 1'b0;
    endtask

    // One clock of u0 stimulus; xa/xb are the hand-computed read results.
    task automatic cyc(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit ea, input logic [4:0] aa, input logic [31:0] xa,
                       input bit eb, input logic [4:0] ab, input logic [31:0] xb);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en_a = ea; rd_addr_a = aa;
        rd_en_b = eb; rd_addr_b = ab;
        if (ea) qa.push_back('{d: xa, due: cyc_cnt + 1});
        if (eb) qb.push_back('{d: xb, due: cyc_cnt + 1});
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // One clock of u1 stimulus, port A only.
    task automatic cyc1(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input bit ea, input logic [4:0] aa, input logic [31:0] xa);
        wr_en1 = we; wr_addr1 = wa; wr_data1 = wd;
        rd_en_a1 = ea; rd_addr_a1 = aa;
        if (ea) q1a.push_back('{d: xa, due: cyc_cnt + 1});
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        idle_inputs();
        wr_addr  = '0; wr_data  = '0; rd_addr_a  = '0; rd_addr_b  = '0;
        wr_addr1 = '0; wr_data1 = '0; rd_addr_a1 = '0; rd_addr_b1 = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("reset_rd_data_a", rd_data_a, 32'h0);
        chk("reset_rd_data_b", rd_data_b, 32'h0);
        chk("reset_rd_vld_a", {31'h0, rd_vld_a}, 32'h0);
        chk("reset_rd_vld_b", {31'h0, rd_vld_b}, 32'h0);
        chk("reset_addr_err", {31'h0, addr_err}, 32'h0);

        // Write then read with one-cycle latency
        cyc(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        cyc(0, 5'd0, 32'h0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);

        // Bypass on both ports, then stored values
        cyc(1, 5'd7, 32'h12345678, 1, 5'd7, 32'h12345678, 1, 5'd7, 32'h12345678);
        cyc(0, 5'd0, 32'h0, 1, 5'd7, 32'h12345678, 1, 5'd5, 32'hDEADBEEF);

        // Hardwired R0: write dropped, zero beats bypass, no error
        cyc(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        cyc(0, 5'd0, 32'h0, 1, 5'd0, 32'h0, 1, 5'd0, 32'h0);
        chk("r0_write_no_err", {31'h0, addr_err}, 32'h0);

        // Without hardwired R0 the same write sticks
        cyc1(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0);
        cyc1(0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFFFFFF);
        cyc1(1, 5'd31, 32'h00000031, 1, 5'd31, 32'h00000031);
        chk("u1_no_err_r31", {31'h0, addr_err1}, 32'h0);

        // Out-of-range read, OOR beats bypass, error is sticky
        cyc(0, 5'd0, 32'h0, 1, 5'd30, 32'd32, 0, 5'd0, 32'h0);
        chk("oor_read_err", {31'h0, addr_err}, 32'h1);
        cyc(1, 5'd30, 32'h55, 0, 5'd0, 32'h0, 1, 5'd30, 32'd32);
        cyc(0, 5'd0, 32'h0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd23, 32'h0);
        chk("err_sticky_inrange", {31'h0, addr_err}, 32'h1);
        cyc(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("hold_rd_data_a", rd_data_a, 32'hDEADBEEF);
        chk("hold_rd_vld_a", {31'h0, rd_vld_a}, 32'h0);

        // Reset wins over a simultaneous write and reads
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
        rd_en_a = 1'b1; rd_addr_a = 5'd7;
        rd_en_b = 1'b1; rd_addr_b = 5'd5;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        chk("rst_rd_data_a", rd_data_a, 32'h0);
        chk("rst_rd_data_b", rd_data_b, 32'h0);
        chk("rst_rd_vld_a", {31'h0, rd_vld_a}, 32'h0);
        chk("rst_rd_vld_b", {31'h0, rd_vld_b}, 32'h0);
        chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
        cyc(0, 5'd0, 32'h0, 1, 5'd3, 32'h0, 1, 5'd7, 32'h0);

        // Out-of-range write sets the error and changes nothing
        cyc(1, 5'd24, 32'hFFFF0000, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        chk("oor_write_err", {31'h0, addr_err}, 32'h1);
        cyc(0, 5'd0, 32'h0, 1, 5'd24, 32'd32, 1, 5'd8, 32'h0);

        // Sweep: fill, then back-to-back reads ascending on A, descending on B
        for (int i = 0; i < 24; i++) begin
            cyc(1, 5'(i), 32'(i * 3), 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        end
        for (int i = 0; i < 24; i++) begin
            cyc(0, 5'd0, 32'h0,
                1, 5'(i), 32'(i * 3),
                1, 5'(23 - i), 32'((23 - i) * 3));
        end
        chk("err_sticky_end", {31'h0, addr_err}, 32'h1);

        repeat (3) @(posedge clk);
        #1;
        chk("qa_drained", 32'(qa.size()), 32'h0);
        chk("qb_drained", 32'(qb.size()), 32'h0);
        chk("q1a_drained", 32'(q1a.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
